// File: rtl/rob_rollback_multicommit_if.sv
// Dispatch / completion / rollback / commit / undo bundle of the reorder buffer.
// The master side is the pipeline driving the ROB, the slave side is the ROB itself.
interface rob_rollback_multicommit_if #(
  parameter int DEPTH = 8,
  parameter int CW    = 2,
  parameter int AR_W  = 5,
  parameter int PR_W  = 6
);
  localparam int IW  = $clog2(DEPTH);
  localparam int CNW = $clog2(DEPTH + 1);

  logic                 disp_valid;
  logic                 disp_ready;
  logic                 disp_has_dest;
  logic [AR_W-1:0]      disp_areg;
  logic [PR_W-1:0]      disp_T;
  logic [PR_W-1:0]      disp_Told;
  logic [IW-1:0]        disp_idx;
  logic                 cdb_valid;
  logic [IW-1:0]        cdb_idx;
  logic                 rb_valid;
  logic [IW-1:0]        rb_idx;
  logic                 rb_busy;
  logic [CW-1:0]        commit_valid;
  logic [CW-1:0]        commit_has_dest;
  logic [CW*AR_W-1:0]   commit_areg;
  logic [CW*PR_W-1:0]   commit_Told;
  logic                 undo_valid;
  logic [AR_W-1:0]      undo_areg;
  logic [PR_W-1:0]      undo_T;
  logic [PR_W-1:0]      undo_Told;
  logic [CNW-1:0]       count;
  logic                 empty;

  modport master (
    output disp_valid, disp_has_dest, disp_areg, disp_T, disp_Told,
           cdb_valid, cdb_idx, rb_valid, rb_idx,
    input  disp_ready, disp_idx, rb_busy, commit_valid, commit_has_dest,
           commit_areg, commit_Told, undo_valid, undo_areg, undo_T, undo_Told,
           count, empty
  );

  modport slave (
    input  disp_valid, disp_has_dest, disp_areg, disp_T, disp_Told,
           cdb_valid, cdb_idx, rb_valid, rb_idx,
    output disp_ready, disp_idx, rb_busy, commit_valid, commit_has_dest,
           commit_areg, commit_Told, undo_valid, undo_areg, undo_T, undo_Told,
           count, empty
  );
endinterface

// File: rtl/rob_rollback_multicommit.sv
// Reorder buffer with CW-wide in-order commit and a one-entry-per-cycle
// mispredict walk that emits map-table undo records youngest-first.
module rob_rollback_multicommit #(
  parameter int DEPTH = 8,
  parameter int CW    = 2,
  parameter int AR_W  = 5,
  parameter int PR_W  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  rob_rollback_multicommit_if.slave  bus
);
  localparam int IW          = $clog2(DEPTH);
  localparam int CNW         = $clog2(DEPTH + 1);
  localparam int DEPTH_M1_I  = DEPTH - 1;
  localparam logic [IW:0]     DEPTH_W  = DEPTH[IW:0];
  localparam logic [IW-1:0]   DEPTH_M1 = DEPTH_M1_I[IW-1:0];
  localparam logic [CNW-1:0]  DEPTH_C  = DEPTH[CNW-1:0];

  typedef enum logic {NORMAL = 1'b0, ROLLBACK = 1'b1} state_t;

  logic             valid_r    [DEPTH];
  logic             done_r     [DEPTH];
  logic             has_dest_r [DEPTH];
  logic [AR_W-1:0]  areg_r     [DEPTH];
  logic [PR_W-1:0]  t_r        [DEPTH];
  logic [PR_W-1:0]  told_r     [DEPTH];
  logic [IW-1:0]    head_r, tail_r, target_r;
  logic [CNW-1:0]   count_r;
  state_t           state_r;

  logic [IW-1:0]    lane_idx_s [CW];
  logic [CW-1:0]    commit_s;
  logic [IW:0]      ncommit_s;
  logic [IW:0]      tgt_dist_s;
  logic [IW-1:0]    last_s;
  logic             undo_step_s, accept_s, cdb_in_range_s, rb_in_range_s;

  // Modular pointer advance; off never exceeds DEPTH so one subtraction suffices.
  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base, input logic [IW:0] off);
    logic [IW+1:0] sum;
    sum = {2'b00, base} + {1'b0, off};
    if (sum >= {1'b0, DEPTH_W}) begin
      sum = sum - {1'b0, DEPTH_W};
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  if ((1 << IW) == DEPTH) begin : g_pow2
    assign cdb_in_range_s = 1'b1;
    assign rb_in_range_s  = 1'b1;
  end else begin : g_npow2
    assign cdb_in_range_s = ({1'b0, bus.cdb_idx} < DEPTH_W);
    assign rb_in_range_s  = ({1'b0, bus.rb_idx} < DEPTH_W);
  end

  assign last_s      = (tail_r == {IW{1'b0}}) ? DEPTH_M1 : tail_r - {{(IW-1){1'b0}}, 1'b1};
  assign undo_step_s = (state_r == ROLLBACK) && (count_r != {CNW{1'b0}}) && (last_s != target_r);
  assign accept_s    = bus.disp_valid && bus.disp_ready;

  // Distance from head to the rollback target, used to stop commit at the branch.
  always_comb begin
    if (target_r >= head_r) begin
      tgt_dist_s = {1'b0, target_r} - {1'b0, head_r};
    end else begin
      tgt_dist_s = {1'b0, target_r} + DEPTH_W - {1'b0, head_r};
    end
  end

  // In-order commit lane selection; during a walk only entries up to the live target retire.
  always_comb begin : lane_sel
    logic run_v;
    logic allow_v;
    commit_s  = {CW{1'b0}};
    ncommit_s = {(IW+1){1'b0}};
    run_v     = 1'b1;
    for (int k = 0; k < CW; k++) begin
      lane_idx_s[k] = idx_add(head_r, k[IW:0]);
      if (state_r == ROLLBACK) begin
        allow_v = valid_r[target_r] && (k[IW:0] <= tgt_dist_s);
      end else begin
        allow_v = 1'b1;
      end
      run_v       = run_v && allow_v && valid_r[lane_idx_s[k]] && done_r[lane_idx_s[k]];
      commit_s[k] = run_v;
      if (run_v) begin
        ncommit_s = ncommit_s + {{IW{1'b0}}, 1'b1};
      end else begin
        ncommit_s = ncommit_s;
      end
    end
  end

  for (genvar g = 0; g < CW; g++) begin : g_lane
    assign bus.commit_has_dest[g]             = commit_s[g] && has_dest_r[lane_idx_s[g]];
    assign bus.commit_areg[g*AR_W +: AR_W]    = areg_r[lane_idx_s[g]];
    assign bus.commit_Told[g*PR_W +: PR_W]    = told_r[lane_idx_s[g]];
  end

  assign bus.commit_valid = commit_s;
  assign bus.disp_ready   = (count_r < DEPTH_C) && (state_r == NORMAL) && !bus.rb_valid;
  assign bus.disp_idx     = tail_r;
  assign bus.rb_busy      = (state_r == ROLLBACK);
  assign bus.undo_valid   = undo_step_s && has_dest_r[last_s];
  assign bus.undo_areg    = areg_r[last_s];
  assign bus.undo_T       = t_r[last_s];
  assign bus.undo_Told    = told_r[last_s];
  assign bus.count        = count_r;
  assign bus.empty        = (count_r == {CNW{1'b0}});

  // Entry storage, pointers, occupancy and the NORMAL/ROLLBACK state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]    <= 1'b0;
        done_r[i]     <= 1'b0;
        has_dest_r[i] <= 1'b0;
        areg_r[i]     <= {AR_W{1'b0}};
        t_r[i]        <= {PR_W{1'b0}};
        told_r[i]     <= {PR_W{1'b0}};
      end
      head_r   <= {IW{1'b0}};
      tail_r   <= {IW{1'b0}};
      target_r <= {IW{1'b0}};
      count_r  <= {CNW{1'b0}};
      state_r  <= NORMAL;
    end else begin
      for (int k = 0; k < CW; k++) begin
        if (commit_s[k]) valid_r[lane_idx_s[k]] <= 1'b0;
      end
      if (undo_step_s) valid_r[last_s] <= 1'b0;
      // A completion for the entry squashed this very cycle must not resurrect it.
      if (bus.cdb_valid && cdb_in_range_s && valid_r[bus.cdb_idx] &&
          !(undo_step_s && (bus.cdb_idx == last_s))) begin
        done_r[bus.cdb_idx] <= 1'b1;
      end
      if (accept_s) begin
        valid_r[tail_r]    <= 1'b1;
        done_r[tail_r]     <= 1'b0;
        has_dest_r[tail_r] <= bus.disp_has_dest;
        areg_r[tail_r]     <= bus.disp_areg;
        t_r[tail_r]        <= bus.disp_T;
        told_r[tail_r]     <= bus.disp_Told;
        tail_r             <= idx_add(tail_r, {{IW{1'b0}}, 1'b1});
      end else if (undo_step_s) begin
        tail_r <= last_s;
      end
      head_r  <= idx_add(head_r, ncommit_s);
      count_r <= count_r + {{(CNW-1){1'b0}}, accept_s} - ncommit_s[CNW-1:0]
                         - {{(CNW-1){1'b0}}, undo_step_s};
      case (state_r)
        NORMAL: begin
          if (bus.rb_valid && rb_in_range_s && valid_r[bus.rb_idx]) begin
            state_r  <= ROLLBACK;
            target_r <= bus.rb_idx;
          end
        end
        ROLLBACK: begin
          if (!undo_step_s) state_r <= NORMAL;
        end
        default: state_r <= NORMAL;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_rollback_multicommit.sv
// Bench for rob_rollback_multicommit: directed scenarios and random traffic on an
// 8-entry ROB checked against a queue model, plus a wrap/rollback run on a 5-entry ROB.
module tb_rob_rollback_multicommit;
  localparam int D   = 8;
  localparam int CW  = 2;
  localparam int ARW = 5;
  localparam int PRW = 6;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rob_rollback_multicommit_if #(.DEPTH(D), .CW(CW), .AR_W(ARW), .PR_W(PRW)) bus8 ();
  rob_rollback_multicommit_if #(.DEPTH(5), .CW(CW), .AR_W(ARW), .PR_W(PRW)) bus5 ();

  rob_rollback_multicommit #(.DEPTH(D), .CW(CW), .AR_W(ARW), .PR_W(PRW)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8));
  rob_rollback_multicommit #(.DEPTH(5), .CW(CW), .AR_W(ARW), .PR_W(PRW)) u_dut5 (
    .clk(clk), .reset(reset), .bus(bus5));

  typedef struct packed {
    int idx;
    bit done;
    bit hd;
    int areg;
    int t;
    int told;
  } ent_t;

  // Reference: program-order list of live instructions, oldest first.
  ent_t q[$];
  int   m_tail;
  bit   m_rb;
  int   m_target;
  bit   exp_ready;
  bit   exp_undo;
  int   exp_n;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail   = 0;
    m_rb     = 1'b0;
    m_target = 0;
  endtask

  task automatic idle8();
    bus8.disp_valid = 1'b0; bus8.disp_has_dest = 1'b0; bus8.disp_areg = 5'd0;
    bus8.disp_T = 6'd0; bus8.disp_Told = 6'd0;
    bus8.cdb_valid = 1'b0; bus8.cdb_idx = 3'd0;
    bus8.rb_valid = 1'b0; bus8.rb_idx = 3'd0;
  endtask

  task automatic idle5();
    bus5.disp_valid = 1'b0; bus5.disp_has_dest = 1'b0; bus5.disp_areg = 5'd0;
    bus5.disp_T = 6'd0; bus5.disp_Told = 6'd0;
    bus5.cdb_valid = 1'b0; bus5.cdb_idx = 3'd0;
    bus5.rb_valid = 1'b0; bus5.rb_idx = 3'd0;
  endtask

  task automatic drive_disp(input bit hd, input int areg, input int t, input int told);
    bus8.disp_valid    = 1'b1;
    bus8.disp_has_dest = hd;
    bus8.disp_areg     = 5'(areg);
    bus8.disp_T        = 6'(t);
    bus8.disp_Told     = 6'(told);
  endtask

  task automatic model_eval();
    int lim;
    exp_ready = (q.size() < D) && !m_rb && !bus8.rb_valid;
    lim = CW;
    if (m_rb) begin
      lim = 0;
      for (int i = 0; i < q.size(); i++) if (q[i].idx == m_target) lim = i + 1;
      if (lim > CW) lim = CW;
    end
    exp_n = 0;
    for (int k = 0; k < lim && k < q.size(); k++) if (q[k].done && exp_n == k) exp_n++;
    exp_undo = 1'b0;
    if (m_rb && q.size() > 0) exp_undo = (q[q.size()-1].idx != m_target);
  endtask

  task automatic model_check();
    int ecv;
    int ehd;
    ecv = (1 << exp_n) - 1;
    ehd = 0;
    check_eq("disp_ready", 64'(bus8.disp_ready), 64'(exp_ready));
    check_eq("disp_idx", 64'(bus8.disp_idx), 64'(m_tail));
    check_eq("count", 64'(bus8.count), 64'(q.size()));
    check_eq("empty", 64'(bus8.empty), 64'(q.size() == 0));
    check_eq("rb_busy", 64'(bus8.rb_busy), 64'(m_rb));
    for (int k = 0; k < exp_n; k++) begin
      if (q[k].hd) ehd = ehd | (1 << k);
      check_eq("commit_areg", 64'(bus8.commit_areg[k*ARW +: ARW]), 64'(q[k].areg));
      check_eq("commit_Told", 64'(bus8.commit_Told[k*PRW +: PRW]), 64'(q[k].told));
    end
    check_eq("commit_valid", 64'(bus8.commit_valid), 64'(ecv));
    check_eq("commit_has_dest", 64'(bus8.commit_has_dest), 64'(ehd));
    if (exp_undo) begin
      check_eq("undo_valid", 64'(bus8.undo_valid), 64'(q[q.size()-1].hd));
      if (q[q.size()-1].hd) begin
        check_eq("undo_areg", 64'(bus8.undo_areg), 64'(q[q.size()-1].areg));
        check_eq("undo_T", 64'(bus8.undo_T), 64'(q[q.size()-1].t));
        check_eq("undo_Told", 64'(bus8.undo_Told), 64'(q[q.size()-1].told));
      end
    end else begin
      check_eq("undo_valid", 64'(bus8.undo_valid), 64'd0);
    end
  endtask

  task automatic model_edge();
    bit   start;
    bit   acc;
    ent_t e;
    acc   = bus8.disp_valid && exp_ready;
    start = 1'b0;
    if (!m_rb && bus8.rb_valid)
      for (int i = 0; i < q.size(); i++) if (q[i].idx == int'(bus8.rb_idx)) start = 1'b1;
    if (bus8.cdb_valid)
      for (int i = 0; i < q.size(); i++) if (q[i].idx == int'(bus8.cdb_idx)) q[i].done = 1'b1;
    for (int k = 0; k < exp_n; k++) q.delete(0);
    if (exp_undo) begin
      q.delete(q.size() - 1);
      m_tail = (m_tail + D - 1) % D;
    end else if (m_rb) begin
      m_rb = 1'b0;
    end
    if (start) begin
      m_rb     = 1'b1;
      m_target = int'(bus8.rb_idx);
    end
    if (acc) begin
      e.idx  = m_tail;
      e.done = 1'b0;
      e.hd   = bus8.disp_has_dest;
      e.areg = int'(bus8.disp_areg);
      e.t    = int'(bus8.disp_T);
      e.told = int'(bus8.disp_Told);
      q.push_back(e);
      m_tail = (m_tail + 1) % D;
    end
  endtask

  // One clock of the 8-entry ROB with the currently driven inputs.
  task automatic cycle8();
    model_eval();
    #1;
    model_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle8();
    idle5();
    #1;
    check_eq("rst_commit_valid", 64'(bus8.commit_valid), 64'd0);
    check_eq("rst_undo_valid", 64'(bus8.undo_valid), 64'd0);
    check_eq("rst_rb_busy", 64'(bus8.rb_busy), 64'd0);
    check_eq("rst_empty", 64'(bus8.empty), 64'd1);
    check_eq("rst_disp_ready", 64'(bus8.disp_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int busy_n;
    do_reset();

    // Fill: indices 0..7, then full.
    for (int i = 0; i < 8; i++) begin
      drive_disp(1'b1, i, 8 + i, 16 + i);
      #1 check_eq("fill_disp_idx", 64'(bus8.disp_idx), 64'(i));
      cycle8();
    end
    #1;
    check_eq("fill_count", 64'(bus8.count), 64'd8);
    check_eq("fill_not_ready", 64'(bus8.disp_ready), 64'd0);
    cycle8();
    idle8();

    // Completion out of order: idx 1 alone commits nothing, then head pair retires.
    bus8.cdb_valid = 1'b1; bus8.cdb_idx = 3'd1;
    cycle8();
    #1 check_eq("cdb1_no_commit", 64'(bus8.commit_valid), 64'd0);
    bus8.cdb_idx = 3'd0;
    cycle8();
    idle8();
    #1 check_eq("pair_commit", 64'(bus8.commit_valid), 64'd3);
    cycle8();
    #1 check_eq("after_pair_count", 64'(bus8.count), 64'd6);

    // Full ROB: a commit in the same cycle does not open a slot for dispatch.
    drive_disp(1'b1, 20, 30, 40);
    cycle8();
    cycle8();
    idle8();
    bus8.cdb_valid = 1'b1; bus8.cdb_idx = 3'd2;
    cycle8();
    idle8();
    drive_disp(1'b0, 21, 31, 41);
    #1;
    check_eq("full_commit_refused", 64'(bus8.disp_ready), 64'd0);
    check_eq("full_commit_lane", 64'(bus8.commit_valid), 64'd1);
    cycle8();
    #1 check_eq("full_next_ready", 64'(bus8.disp_ready), 64'd1);
    cycle8();
    idle8();
    #1 check_eq("full_again_count", 64'(bus8.count), 64'd8);

    // Rollback of 6 entries to target 2; idx 4 has no destination.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_disp(i != 4, i, 20 + i, 30 + i);
      cycle8();
    end
    idle8();
    bus8.rb_valid = 1'b1; bus8.rb_idx = 3'd2;
    cycle8();
    idle8();
    busy_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.rb_busy) begin
        busy_n++;
        if (busy_n == 1) check_eq("rb_undo_first_T", 64'(bus8.undo_T), 64'd25);
        if (busy_n == 2) check_eq("rb_undo_nodest", 64'(bus8.undo_valid), 64'd0);
        if (busy_n == 3) check_eq("rb_undo_third_T", 64'(bus8.undo_T), 64'd23);
        cycle8();
      end
    end
    check_eq("rb_busy_cycles", 64'(busy_n), 64'd4);
    check_eq("rb_final_tail", 64'(bus8.disp_idx), 64'd3);
    check_eq("rb_final_count", 64'(bus8.count), 64'd3);
    check_eq("rb_final_ready", 64'(bus8.disp_ready), 64'd1);

    // Stale events: completion to a squashed slot, rollback to an empty slot.
    bus8.cdb_valid = 1'b1; bus8.cdb_idx = 3'd5;
    cycle8();
    idle8();
    bus8.rb_valid = 1'b1; bus8.rb_idx = 3'd6;
    cycle8();
    idle8();
    #1;
    check_eq("stale_rb_busy", 64'(bus8.rb_busy), 64'd0);
    check_eq("stale_commit", 64'(bus8.commit_valid), 64'd0);

    // Reset in the middle of a walk.
    drive_disp(1'b1, 3, 3, 3);
    cycle8();
    cycle8();
    idle8();
    bus8.rb_valid = 1'b1; bus8.rb_idx = 3'd0;
    cycle8();
    idle8();
    cycle8();
    reset = 1'b1;
    #1;
    check_eq("midrb_empty", 64'(bus8.empty), 64'd1);
    check_eq("midrb_busy", 64'(bus8.rb_busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      idle8();
      if ($urandom_range(0, 9) < 7)
        drive_disp($urandom_range(0, 1) != 0, int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 9) < 6) begin
        bus8.cdb_valid = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          bus8.cdb_idx = 3'(q[$urandom_range(0, q.size() - 1)].idx);
        else
          bus8.cdb_idx = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) begin
        bus8.rb_valid = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 2) != 0)
          bus8.rb_idx = 3'(q[$urandom_range(0, q.size() - 1)].idx);
        else
          bus8.rb_idx = 3'($urandom_range(0, 7));
      end
      cycle8();
    end
    idle8();

    // Five-entry ROB: pointer wrap, then rollback across the wrap point.
    for (int i = 0; i < 12; i++) begin
      bus5.disp_valid = 1'b1; bus5.disp_has_dest = 1'b1;
      bus5.disp_areg = 5'(i); bus5.disp_T = 6'(i); bus5.disp_Told = 6'(i + 20);
      #1 check_eq("wrap_disp_idx", 64'(bus5.disp_idx), 64'(i % 5));
      @(posedge clk); @(negedge clk);
      idle5();
      bus5.cdb_valid = 1'b1; bus5.cdb_idx = 3'(i % 5);
      @(posedge clk); @(negedge clk);
      idle5();
      #1;
      check_eq("wrap_commit", 64'(bus5.commit_valid), 64'd1);
      check_eq("wrap_commit_Told", 64'(bus5.commit_Told[PRW-1:0]), 64'(i + 20));
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      bus5.disp_valid = 1'b1; bus5.disp_has_dest = 1'b1;
      bus5.disp_areg = 5'(i); bus5.disp_T = 6'(40 + (2 + i) % 5); bus5.disp_Told = 6'd0;
      #1 check_eq("wrap2_disp_idx", 64'(bus5.disp_idx), 64'((2 + i) % 5));
      @(posedge clk); @(negedge clk);
    end
    idle5();
    bus5.rb_valid = 1'b1; bus5.rb_idx = 3'd3;
    @(posedge clk); @(negedge clk);
    idle5();
    #1;
    check_eq("wrap_rb_undo0_v", 64'(bus5.undo_valid), 64'd1);
    check_eq("wrap_rb_undo0_T", 64'(bus5.undo_T), 64'd40);
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("wrap_rb_undo4_v", 64'(bus5.undo_valid), 64'd1);
    check_eq("wrap_rb_undo4_T", 64'(bus5.undo_T), 64'd44);
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("wrap_rb_stop_v", 64'(bus5.undo_valid), 64'd0);
    check_eq("wrap_rb_stop_busy", 64'(bus5.rb_busy), 64'd1);
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("wrap_rb_done_busy", 64'(bus5.rb_busy), 64'd0);
    check_eq("wrap_rb_count", 64'(bus5.count), 64'd2);
    check_eq("wrap_rb_tail", 64'(bus5.disp_idx), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
